uart_tx_buf: RTL and testbench
==============================

Name: uart_tx_buf

Overview:
- Byte buffer and issue controller placed directly upstream of the UART transmitter.
- Accepts bytes from the PCIe/RGMII-side logic into a synchronous FIFO.
- Hands bytes one at a time to the transmitter's din/din_vld/rdy interface.
- Optionally enforces an idle gap between frames, and reports level, overflow and busy status.

Parameters:
DEPTH, 16, FIFO entries; power of 2, minimum 2.
GAP_CYCLES, 0, extra idle clk_125m cycles inserted after the transmitter returns ready and before the next byte is issued; 0 means no gap.

Ports:
clk_125m  in  1  system clock, 125 MHz.
rst_n  in  1  reset; asynchronous assert, active-low.
wr_data  in  8  byte to enqueue.
wr_en  in  1  enqueue strobe, sampled each clock.
flush  in  1  synchronous FIFO clear.
ovf_clr  in  1  clears the overflow sticky bit.
full  out  1  FIFO level equals DEPTH.
empty  out  1  FIFO level equals 0.
level  out  $clog2(DEPTH)+1  current FIFO occupancy.
overflow  out  1  sticky; set when a write is dropped because the FIFO is full.
busy  out  1  high when state is not IDLE or the FIFO is not empty.
tx_din  out  8  byte to the transmitter's din.
tx_din_vld  out  1  single-cycle strobe to the transmitter's din_vld.
tx_rdy  in  1  transmitter ready. It is combinational in the sink and may drop in the same cycle tx_din_vld is high.

Behaviour:
- Clock and reset: single clock domain, clk_125m; rst_n is asynchronous, active-low.
- Reset values: tx_din=0, tx_din_vld=0, full=0, empty=1, level=0, overflow=0, busy=0, state=IDLE, pointers=0, gap counter=0.
- All outputs are registered or decoded from registers only. tx_din_vld must not depend combinationally on tx_rdy.
- Write rules:
  - wr_en && !full && !flush: store at wr_ptr, wr_ptr wraps modulo DEPTH, level+1.
  - wr_en && full: byte dropped, overflow<=1, level unchanged.
  - full is evaluated on the pre-edge level; a same-cycle pop does not make room.
- Simultaneous write and pop with level<DEPTH: both occur and level is unchanged.
- FSM states: IDLE, SENT, BUSY, GAP.
  - IDLE: if !empty && tx_rdy && !flush, pop. In that cycle tx_din<=mem[rd_ptr], rd_ptr+1, level-1, tx_din_vld<=1, next state SENT. Otherwise stay in IDLE.
  - SENT (tx_din_vld is high for exactly this one cycle): tx_din_vld<=0, next state BUSY. tx_rdy is ignored in this state.
  - BUSY: wait for tx_rdy==1. When it is seen, go to IDLE if GAP_CYCLES==0; otherwise clear the gap counter and go to GAP.
  - GAP: increment the counter each cycle; when counter==GAP_CYCLES-1, go to IDLE.
- Latency:
  - wr_en in cycle N with empty FIFO, IDLE and tx_rdy=1: tx_din_vld is high in cycle N+2.
  - tx_rdy rising seen in BUSY at cycle M with GAP_CYCLES=0 and FIFO non-empty: next tx_din_vld at M+2.
  - With GAP_CYCLES=G: next tx_din_vld at M+2+G.
- tx_din holds its last value while tx_din_vld is low.
- Flush:
  - Clears pointers and level in one cycle; empty=1 and full=0 on the next cycle.
  - A wr_en in the same cycle is discarded without setting overflow.
  - Does not abort a byte already issued; SENT/BUSY/GAP complete normally.
  - Does not touch overflow.
- Overflow: if set and ovf_clr occur in the same cycle, set wins.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full and empty derive from level, never from pointer compare.
- Reset mid-operation: everything returns to reset values immediately. Any byte in the FIFO is lost. A byte already handed to the transmitter is the transmitter's concern.

Test Plan:
- Single byte: write 0xA5 into an empty FIFO, sink rdy=1 → tx_din=0xA5 with tx_din_vld high for exactly 1 cycle, 2 cycles after wr_en. Then level=0, empty=1, and busy falls once the FSM is back in IDLE.
- Back-to-back (sink model: rdy=0 while din_vld is high, then low for 20 cycles, then high): write 0x11, 0x22, 0x33 on consecutive cycles → three strobes in order 0x11, 0x22, 0x33. No strobe is issued while rdy is low; each strobe occurs exactly 2 cycles after rdy returns high.
- Overflow, DEPTH=16, sink rdy held 0: write 17 bytes 0x00..0x10 → full=1, level=16, overflow=1. Release rdy → 0x00..0x0F are emitted and 0x10 is never emitted. Pulse ovf_clr → overflow=0.
- Flush with a transfer in flight: 5 bytes queued, first issued, assert flush during BUSY → level=0 next cycle and no further strobes after the sink returns rdy. Also assert wr_en together with flush → byte dropped, overflow stays 0.
- Gap, GAP_CYCLES=100: two queued bytes, sink rdy returns high at cycle M → second tx_din_vld at exactly M+102.
- Reset mid-operation: 4 bytes queued, state BUSY, pulse rst_n low for 1 cycle → all outputs at reset values immediately. No tx_din_vld afterwards until a new write.

Source files
------------

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: byte FIFO plus issue controller feeding a UART transmitter.
// Bytes are issued one at a time as a single-cycle din_vld strobe, and the
// next byte waits until the sink reports ready again. An optional idle gap
// can be inserted between frames. Every output comes straight from a flop or
// from a decode of flops, so nothing here is combinational on tx_rdy.
module uart_tx_buf #(
   parameter int DEPTH      = 16,
   parameter int GAP_CYCLES = 0
) (
   input  logic                     clk_125m,
   input  logic                     rst_n,
   input  logic [7:0]               wr_data,
   input  logic                     wr_en,
   input  logic                     flush,
   input  logic                     ovf_clr,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic                     busy,
   output logic [7:0]               tx_din,
   output logic                     tx_din_vld,
   input  logic                     tx_rdy
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SENT = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ovf_q, ovf_d;
   logic [1:0]    state_q, state_d;
   logic [GW-1:0] gap_q, gap_d;
   logic [7:0]    din_q, din_d;
   logic          vld_q, vld_d;

   logic push, pop, drop;

   // Status decodes. full/empty come from the level count, never from a
   // pointer compare, so wrap-around needs no extra pointer bit.
   assign full       = (level_q == LW'(DEPTH));
   assign empty      = (level_q == '0);
   assign level      = level_q;
   assign overflow   = ovf_q;
   assign busy       = (state_q != S_IDLE) || !empty;
   assign tx_din     = din_q;
   assign tx_din_vld = vld_q;

   // full is the pre-edge value, so a pop in the same cycle never frees room
   // for a write. Flush discards any same-cycle write without flagging it.
   assign push = wr_en && !full && !flush;
   assign drop = wr_en &&  full && !flush;
   assign pop  = (state_q == S_IDLE) && !empty && tx_rdy && !flush;

   // Pointer, level and sticky-overflow next state.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   // Issue FSM: pop in IDLE, strobe for one cycle in SENT, wait for ready in
   // BUSY, then optionally idle for GAP_CYCLES before the next byte.
   always_comb begin
      state_d = state_q;
      gap_d   = gap_q;
      din_d   = din_q;
      vld_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               din_d   = mem[rd_ptr_q];
               vld_d   = 1'b1;
               state_d = S_SENT;
            end
         end
         S_SENT: state_d = S_BUSY;
         S_BUSY: begin
            if (tx_rdy) begin
               if (GAP_CYCLES == 0) begin
                  state_d = S_IDLE;
               end else begin
                  gap_d   = '0;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_d = S_IDLE;
            else                   gap_d   = gap_q + GW'(1);
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control and output registers.
   always_ff @(posedge clk_125m or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         state_q  <= S_IDLE;
         gap_q    <= '0;
         din_q    <= '0;
         vld_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         state_q  <= state_d;
         gap_q    <= gap_d;
         din_q    <= din_d;
         vld_q    <= vld_d;
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_125m) begin
      if (push) mem[wr_ptr_q] <= wr_data;
   end

endmodule

// File: tb/tb_uart_tx_buf.sv
// tb_uart_tx_buf: two instances (no gap, 100-cycle gap) driven with the same
// directed and random stimulus, checked every cycle against a queue/timestamp
// reference model, plus explicit ordering and latency checks.
module tb_uart_tx_buf;

   localparam int DEPTH = 16;
   localparam int G1    = 100;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk_125m = 1'b0;
   logic          rst_n    = 1'b0;
   logic [7:0]    wr_data  = '0;
   logic          wr_en    = 1'b0;
   logic          flush    = 1'b0;
   logic          ovf_clr  = 1'b0;
   logic          rdy   [2];
   logic          full  [2];
   logic          empty [2];
   logic          ovf   [2];
   logic          busy  [2];
   logic          vld   [2];
   logic [LW-1:0] lvl   [2];
   logic [7:0]    din   [2];

   always #4 clk_125m = ~clk_125m;

   uart_tx_buf #(.DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
      .clk_125m(clk_125m), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
      .flush(flush), .ovf_clr(ovf_clr), .full(full[0]), .empty(empty[0]),
      .level(lvl[0]), .overflow(ovf[0]), .busy(busy[0]), .tx_din(din[0]),
      .tx_din_vld(vld[0]), .tx_rdy(rdy[0]));

   uart_tx_buf #(.DEPTH(DEPTH), .GAP_CYCLES(G1)) dut1 (
      .clk_125m(clk_125m), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en),
      .flush(flush), .ovf_clr(ovf_clr), .full(full[1]), .empty(empty[1]),
      .level(lvl[1]), .overflow(ovf[1]), .busy(busy[1]), .tx_din(din[1]),
      .tx_din_vld(vld[1]), .tx_rdy(rdy[1]));

   // Reference model: a byte queue, the pending strobe, whether a ready is
   // still owed by the sink, and the first cycle a new byte may be issued.
   logic [7:0] mq [2][$];
   bit         m_vld [2];
   bit         m_wt  [2];
   bit         m_ovf [2];
   logic [7:0] m_din [2];
   int         m_idle_at [2];

   int cyc = 0;
   int n_asrt = 0;
   int n_fail = 0;

   bit         auto_snk = 1'b0;
   int         hold [2];
   int         rise [2][$];
   logic [7:0] sd   [2][$];
   int         sc   [2][$];

   function automatic int gap_of(int m);
      return (m == 0) ? 0 : G1;
   endfunction

   task automatic chk(string tag, int m, logic [31:0] obs, logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[dut%0d]: observed %0h expected %0h", tag, m, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mq[m].delete();
         m_vld[m] = 1'b0;
         m_wt[m]  = 1'b0;
         m_ovf[m] = 1'b0;
         m_din[m] = '0;
         m_idle_at[m] = 0;
      end
   endtask

   // One clock edge of the model, using the inputs present at that edge.
   task automatic model_edge(int m);
      int  n;
      bit  idle, pop, full_p;
      n      = mq[m].size();
      full_p = (n == DEPTH);
      idle   = !m_vld[m] && !m_wt[m] && (cyc >= m_idle_at[m]);
      pop    = idle && (n > 0) && (rdy[m] === 1'b1) && !flush;
      if (!m_vld[m] && m_wt[m] && rdy[m] === 1'b1) begin
         m_wt[m]      = 1'b0;
         m_idle_at[m] = cyc + 1 + gap_of(m);
      end
      m_vld[m] = 1'b0;
      if (pop) begin
         m_din[m] = mq[m].pop_front();
         m_vld[m] = 1'b1;
         m_wt[m]  = 1'b1;
      end
      if (flush) mq[m].delete();
      else if (wr_en && !full_p) mq[m].push_back(wr_data);
      if (wr_en && !flush && full_p) m_ovf[m] = 1'b1;
      else if (ovf_clr)              m_ovf[m] = 1'b0;
   endtask

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         chk("level", m, 32'(lvl[m]), mq[m].size());
         chk("full", m, 32'(full[m]), 32'(mq[m].size() == DEPTH));
         chk("empty", m, 32'(empty[m]), 32'(mq[m].size() == 0));
         chk("overflow", m, 32'(ovf[m]), 32'(m_ovf[m]));
         chk("busy", m, 32'(busy[m]),
             32'(m_vld[m] || m_wt[m] || (cyc < m_idle_at[m]) || mq[m].size() > 0));
         chk("tx_din_vld", m, 32'(vld[m]), 32'(m_vld[m]));
         chk("tx_din", m, 32'(din[m]), 32'(m_din[m]));
      end
   endtask

   // Advance one cycle: model edge, sample #1 later, log strobes, run sink.
   task automatic step();
      @(posedge clk_125m);
      if (!rst_n) model_reset();
      else for (int m = 0; m < 2; m++) model_edge(m);
      cyc++;
      #1;
      check_all();
      for (int m = 0; m < 2; m++) begin
         if (vld[m] === 1'b1) begin
            sd[m].push_back(din[m]);
            sc[m].push_back(cyc);
         end
         if (auto_snk) begin
            if (vld[m] === 1'b1) begin
               rdy[m]  = 1'b0;
               hold[m] = 20;
            end else if (hold[m] > 0) begin
               rdy[m] = 1'b0;
               hold[m]--;
            end else begin
               if (rdy[m] === 1'b0) rise[m].push_back(cyc);
               rdy[m] = 1'b1;
            end
         end
      end
   endtask

   task automatic set_rdy(logic v);
      auto_snk = 1'b0;
      rdy[0] = v;
      rdy[1] = v;
   endtask

   task automatic start_auto();
      auto_snk = 1'b1;
      hold[0] = 0;
      hold[1] = 0;
   endtask

   task automatic clear_logs();
      for (int m = 0; m < 2; m++) begin
         sd[m].delete();
         sc[m].delete();
         rise[m].delete();
      end
   endtask

   task automatic wait_idle(int budget);
      int k;
      k = 0;
      while ((busy[0] === 1'b1 || busy[1] === 1'b1) && k < budget) begin
         step();
         k++;
      end
      chk("idle_timeout", 0, 32'(busy[0] | busy[1]), 32'd0);
   endtask

   task automatic wr(logic [7:0] b);
      wr_en   = 1'b1;
      wr_data = b;
      step();
      wr_en   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rdy[0] = 1'b1;
      rdy[1] = 1'b1;
      hold[0] = 0;
      hold[1] = 0;
      model_reset();

      // Reset state, sampled while rst_n is still low.
      #1;
      check_all();
      step();
      step();
      rst_n = 1'b1;
      step();

      // Single byte with the sink always ready.
      set_rdy(1'b1);
      clear_logs();
      t0 = cyc;
      wr(8'hA5);
      step();
      for (int m = 0; m < 2; m++) begin
         chk("single_lat", m, 32'(cyc - t0), 32'd2);
         chk("single_vld", m, 32'(vld[m]), 32'd1);
         chk("single_din", m, 32'(din[m]), 32'hA5);
      end
      step();
      for (int m = 0; m < 2; m++) begin
         chk("single_one_cycle", m, 32'(vld[m]), 32'd0);
         chk("single_din_hold", m, 32'(din[m]), 32'hA5);
      end
      repeat (110) step();
      for (int m = 0; m < 2; m++) begin
         chk("single_level", m, 32'(lvl[m]), 32'd0);
         chk("single_empty", m, 32'(empty[m]), 32'd1);
         chk("single_busy", m, 32'(busy[m]), 32'd0);
      end

      // Back-to-back with a sink that drops ready for 21 cycles per byte.
      clear_logs();
      start_auto();
      wr(8'h11);
      wr(8'h22);
      wr(8'h33);
      wait_idle(1000);
      for (int m = 0; m < 2; m++) begin
         chk("b2b_count", m, 32'(sd[m].size()), 32'd3);
         for (int k = 0; k < 3 && k < sd[m].size(); k++)
            chk("b2b_data", m, 32'(sd[m][k]), 32'(8'h11 * (k + 1)));
         for (int k = 1; k < 3 && k < sc[m].size() && k <= rise[m].size(); k++)
            chk("b2b_latency", m, 32'(sc[m][k]), 32'(rise[m][k-1] + 2 + gap_of(m)));
      end

      // Overflow with the sink held off, then drain.
      set_rdy(1'b0);
      clear_logs();
      for (int k = 0; k < 17; k++) wr(8'(k));
      for (int m = 0; m < 2; m++) begin
         chk("ovf_full", m, 32'(full[m]), 32'd1);
         chk("ovf_level", m, 32'(lvl[m]), 32'd16);
         chk("ovf_flag", m, 32'(ovf[m]), 32'd1);
      end
      ovf_clr = 1'b1;
      wr(8'h99);
      ovf_clr = 1'b0;
      for (int m = 0; m < 2; m++) chk("ovf_set_wins", m, 32'(ovf[m]), 32'd1);
      set_rdy(1'b1);
      wait_idle(2500);
      for (int m = 0; m < 2; m++) begin
         chk("ovf_count", m, 32'(sd[m].size()), 32'd16);
         for (int k = 0; k < sd[m].size(); k++)
            chk("ovf_data", m, 32'(sd[m][k]), 32'(k));
      end
      ovf_clr = 1'b1;
      step();
      ovf_clr = 1'b0;
      for (int m = 0; m < 2; m++) chk("ovf_clear", m, 32'(ovf[m]), 32'd0);

      // Flush during BUSY, with a write in the same cycle.
      clear_logs();
      start_auto();
      for (int k = 0; k < 5; k++) wr(8'h40 + 8'(k));
      flush   = 1'b1;
      wr(8'hEE);
      flush   = 1'b0;
      for (int m = 0; m < 2; m++) begin
         chk("flush_level", m, 32'(lvl[m]), 32'd0);
         chk("flush_empty", m, 32'(empty[m]), 32'd1);
         chk("flush_ovf", m, 32'(ovf[m]), 32'd0);
      end
      repeat (300) step();
      for (int m = 0; m < 2; m++) chk("flush_strobes", m, 32'(sd[m].size()), 32'd1);

      // Asynchronous reset with bytes queued and the FSM in BUSY.
      clear_logs();
      for (int k = 0; k < 4; k++) wr(8'h50 + 8'(k));
      step();
      #2;
      rst_n = 1'b0;
      #2;
      for (int m = 0; m < 2; m++) begin
         chk("rst_vld", m, 32'(vld[m]), 32'd0);
         chk("rst_din", m, 32'(din[m]), 32'd0);
         chk("rst_level", m, 32'(lvl[m]), 32'd0);
         chk("rst_empty", m, 32'(empty[m]), 32'd1);
         chk("rst_busy", m, 32'(busy[m]), 32'd0);
      end
      model_reset();
      step();
      rst_n = 1'b1;
      repeat (50) step();
      for (int m = 0; m < 2; m++) chk("rst_strobes", m, 32'(sd[m].size()), 32'd1);

      // Random traffic against the model.
      for (int i = 0; i < 800; i++) begin
         wr_en   = 1'($urandom_range(0, 1));
         wr_data = 8'($urandom);
         flush   = ($urandom_range(0, 49) == 0);
         ovf_clr = ($urandom_range(0, 19) == 0);
         set_rdy($urandom_range(0, 9) < 7);
         step();
      end
      wr_en   = 1'b0;
      flush   = 1'b0;
      ovf_clr = 1'b0;
      set_rdy(1'b1);
      wait_idle(2500);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
